// File: rtl/morse_pkg.sv
// Shared Morse encoding constants: pattern/length widths, FSM states,
// timing thresholds in units, and the accumulated-symbol payload.
package morse_pkg;

  localparam int unsigned PATTERN_W      = 5;
  localparam int unsigned LEN_W          = 3;
  localparam int unsigned UNIT_W         = 3;
  localparam int unsigned MAX_LEN        = 5;

  localparam int unsigned DASH_UNITS     = 2;
  localparam int unsigned CHAR_GAP_UNITS = 2;
  localparam int unsigned WORD_GAP_UNITS = 5;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MARK  = 2'd1;
  localparam logic [1:0] ST_SPACE = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // Newest element in pattern bit 0; 1 = dash, 0 = dot.
  typedef struct packed {
    logic [PATTERN_W-1:0] pattern;
    logic [LEN_W-1:0]     len;
  } morse_sym_t;

endpackage

// File: rtl/morse_to_ascii.sv
// Combinational Morse pattern/length to ASCII lookup for A-Z and 0-9.
// Any pattern/length pair outside that set drives valid low.
module morse_to_ascii
  import morse_pkg::*;
(
  input  logic [PATTERN_W-1:0] pattern,
  input  logic [LEN_W-1:0]     len,
  output logic [7:0]           ascii,
  output logic                 valid
);

  always_comb begin
    ascii = 8'h00;
    valid = 1'b1;
    case ({len, pattern})
      {3'd1, 5'b00000}: ascii = "E";
      {3'd1, 5'b00001}: ascii = "T";
      {3'd2, 5'b00000}: ascii = "I";
      {3'd2, 5'b00001}: ascii = "A";
      {3'd2, 5'b00010}: ascii = "N";
      {3'd2, 5'b00011}: ascii = "M";
      {3'd3, 5'b00000}: ascii = "S";
      {3'd3, 5'b00001}: ascii = "U";
      {3'd3, 5'b00010}: ascii = "R";
      {3'd3, 5'b00011}: ascii = "W";
      {3'd3, 5'b00100}: ascii = "D";
      {3'd3, 5'b00101}: ascii = "K";
      {3'd3, 5'b00110}: ascii = "G";
      {3'd3, 5'b00111}: ascii = "O";
      {3'd4, 5'b00000}: ascii = "H";
      {3'd4, 5'b00001}: ascii = "V";
      {3'd4, 5'b00010}: ascii = "F";
      {3'd4, 5'b00100}: ascii = "L";
      {3'd4, 5'b00110}: ascii = "P";
      {3'd4, 5'b00111}: ascii = "J";
      {3'd4, 5'b01000}: ascii = "B";
      {3'd4, 5'b01001}: ascii = "X";
      {3'd4, 5'b01010}: ascii = "C";
      {3'd4, 5'b01011}: ascii = "Y";
      {3'd4, 5'b01100}: ascii = "Z";
      {3'd4, 5'b01101}: ascii = "Q";
      {3'd5, 5'b11111}: ascii = "0";
      {3'd5, 5'b01111}: ascii = "1";
      {3'd5, 5'b00111}: ascii = "2";
      {3'd5, 5'b00011}: ascii = "3";
      {3'd5, 5'b00001}: ascii = "4";
      {3'd5, 5'b00000}: ascii = "5";
      {3'd5, 5'b10000}: ascii = "6";
      {3'd5, 5'b11000}: ascii = "7";
      {3'd5, 5'b11100}: ascii = "8";
      {3'd5, 5'b11110}: ascii = "9";
      default:          valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_key_decoder.sv
// Hand-keyed Morse receiver: synchronize and debounce the key, time marks and
// spaces in units, and emit one ASCII byte (or error) per character plus word spaces.
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int unsigned CLKS_PER_UNIT = 1_500_000,
  parameter int unsigned DEBOUNCE_CLKS = 250_000
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_Key,
  output logic       o_Key,
  output logic       o_Char_DV,
  output logic [7:0] o_Char,
  output logic       o_Err
);

  localparam int unsigned TICK_W = (CLKS_PER_UNIT > 1) ? $clog2(CLKS_PER_UNIT) : 1;
  localparam int unsigned DB_W   = (DEBOUNCE_CLKS > 0) ? $clog2(DEBOUNCE_CLKS + 1) : 1;

  logic              key_meta, key_sync, key_db_d1;
  logic [DB_W-1:0]   db_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic [UNIT_W-1:0] unit_cnt;
  logic              key_rise, key_fall, is_dash;

  logic [1:0]        state, state_d;
  morse_sym_t        sym, sym_d;
  logic              ovf, ovf_d;
  logic [7:0]        char_d;
  logic              char_dv_d, err_d;
  logic [7:0]        lut_ascii;
  logic              lut_valid;

  // Two-flop synchronizer and stability debounce; o_Key is the debounced level.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      key_meta  <= 1'b0;
      key_sync  <= 1'b0;
      o_Key     <= 1'b0;
      key_db_d1 <= 1'b0;
      db_cnt    <= '0;
    end else begin
      key_meta  <= i_Key;
      key_sync  <= key_meta;
      key_db_d1 <= o_Key;
      if (key_sync != o_Key) begin
        if (db_cnt == DB_W'(DEBOUNCE_CLKS)) begin
          o_Key  <= key_sync;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign key_rise = o_Key & ~key_db_d1;
  assign key_fall = ~o_Key & key_db_d1;
  assign is_dash  = (unit_cnt >= UNIT_W'(DASH_UNITS));

  // Unit timer restarts on every debounced edge; unit count saturates.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tick_cnt <= '0;
      unit_cnt <= '0;
    end else if (key_rise || key_fall) begin
      tick_cnt <= '0;
      unit_cnt <= '0;
    end else if (tick_cnt == TICK_W'(CLKS_PER_UNIT - 1)) begin
      tick_cnt <= '0;
      if (unit_cnt != '1) unit_cnt <= unit_cnt + UNIT_W'(1);
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  morse_to_ascii u_lut (
    .pattern (sym.pattern),
    .len     (sym.len),
    .ascii   (lut_ascii),
    .valid   (lut_valid)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state     <= ST_IDLE;
      sym       <= '0;
      ovf       <= 1'b0;
      o_Char    <= 8'h00;
      o_Char_DV <= 1'b0;
      o_Err     <= 1'b0;
    end else begin
      state     <= state_d;
      sym       <= sym_d;
      ovf       <= ovf_d;
      o_Char    <= char_d;
      o_Char_DV <= char_dv_d;
      o_Err     <= err_d;
    end
  end

  always_comb begin
    state_d   = state;
    sym_d     = sym;
    ovf_d     = ovf;
    char_d    = o_Char;
    char_dv_d = 1'b0;
    err_d     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_rise) begin
          state_d = ST_MARK;
          sym_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_MARK: begin
        if (key_fall) begin
          if (sym.len == LEN_W'(MAX_LEN)) begin
            ovf_d = 1'b1;
          end else begin
            sym_d.pattern = {sym.pattern[PATTERN_W-2:0], is_dash};
            sym_d.len     = sym.len + LEN_W'(1);
          end
          state_d = ST_SPACE;
        end
      end
      ST_SPACE: begin
        if (unit_cnt >= UNIT_W'(CHAR_GAP_UNITS)) begin
          if (ovf || !lut_valid) begin
            err_d = 1'b1;
          end else begin
            char_d    = lut_ascii;
            char_dv_d = 1'b1;
          end
          // A press landing on the char-end cycle starts the next character.
          if (key_rise) begin
            state_d = ST_MARK;
            sym_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = ST_GAP;
          end
        end else if (key_rise) begin
          state_d = ST_MARK;
        end
      end
      ST_GAP: begin
        if (key_rise) begin
          state_d = ST_MARK;
          sym_d   = '0;
          ovf_d   = 1'b0;
        end else if (unit_cnt >= UNIT_W'(WORD_GAP_UNITS)) begin
          char_d    = ASCII_SPACE;
          char_dv_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
